// File: rtl/dmem_sram_bridge_pkg.sv
// ============================================================================
// Module  : dmem_sram_bridge_pkg
// Brief   : Shared state encodings and bus size codes for the dmem SRAM bridge.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package dmem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    DB_IDLE = 2'b00,
    DB_REQ  = 2'b01,
    DB_WAIT = 2'b10,
    DB_DONE = 2'b11
  } db_state_e;

  typedef logic [1:0] size_t;

  localparam size_t SIZE_B = 2'b00;
  localparam size_t SIZE_H = 2'b01;
  localparam size_t SIZE_W = 2'b10;

endpackage

`default_nettype wire

// File: rtl/dmem_size_dec.sv
// ============================================================================
// Module  : dmem_size_dec
// Brief   : Byte-lane select to bus size decode, with alignment legality.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dmem_size_dec
  import dmem_sram_bridge_pkg::*;
(
  input  logic [3:0] memsel,
  input  logic [1:0] addr_lo,
  output size_t      size,
  output logic       legal
);

  // memsel[3] is the lane at addr[1:0]==00
  always_comb begin
    size  = SIZE_W;
    legal = 1'b0;
    case (memsel)
      4'b1111: begin
        size  = SIZE_W;
        legal = (addr_lo == 2'b00);
      end
      4'b1100, 4'b0011: begin
        size  = SIZE_H;
        legal = ~addr_lo[0];
      end
      4'b1000, 4'b0100, 4'b0010, 4'b0001: begin
        size  = SIZE_B;
        legal = 1'b1;
      end
      default: begin
        size  = SIZE_W;
        legal = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_sram_bridge.sv
// ============================================================================
// Module  : dmem_sram_bridge
// Brief   : M-stage bridge from the byte-lane decoder to a req/ack SRAM bus;
//           optional DMEM_ALIGN_CHK_EN adds adel/ades alignment faults.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [3:0]        memsel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              ext_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_req,
`ifdef DMEM_ALIGN_CHK_EN
  output logic              adel,
  output logic              ades,
`endif
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  db_state_e         state_q, state_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_wr_q, req_wr_d;
  size_t             req_size_q, req_size_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  size_t dec_size;
  logic  dec_legal;
  logic  access_ok;

  dmem_size_dec u_size_dec (
    .memsel  (memsel),
    .addr_lo (mem_addr[1:0]),
    .size    (dec_size),
    .legal   (dec_legal)
  );

`ifdef DMEM_ALIGN_CHK_EN
  logic chk_bad;
  assign access_ok = dec_legal;
  assign chk_bad   = ~rst & (state_q == DB_IDLE) & mem_ce & ~flush & ~dec_legal;
  assign adel      = chk_bad & ~mem_we;
  assign ades      = chk_bad & mem_we;
`else
  logic unused_legal;
  assign access_ok    = 1'b1;
  assign unused_legal = dec_legal;
`endif

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    req_addr_d  = req_addr_q;
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_wdata_d = req_wdata_q;
    rbuf_d      = rbuf_q;

    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = SIZE_B;
    data_addr   = '0;
    data_wdata  = '0;
    stall_req   = 1'b0;
    mem_rdata   = rbuf_q;

    // Outputs track the asynchronous reset immediately, not just after the flops clear.
    if (!rst) begin
      unique case (state_q)
        DB_IDLE: begin
          if (mem_ce && !flush && access_ok) begin
            data_req    = 1'b1;
            stall_req   = 1'b1;
            data_addr   = mem_addr;
            data_wr     = mem_we;
            data_size   = dec_size;
            data_wdata  = mem_wdata;
            req_addr_d  = mem_addr;
            req_wr_d    = mem_we;
            req_size_d  = dec_size;
            req_wdata_d = mem_wdata;
            state_d     = data_addr_ok ? DB_WAIT : DB_REQ;
          end
        end

        DB_REQ: begin
          if (flush) begin
            state_d = DB_IDLE;
          end else begin
            data_req   = 1'b1;
            stall_req  = 1'b1;
            data_addr  = req_addr_q;
            data_wr    = req_wr_q;
            data_size  = req_size_q;
            data_wdata = req_wdata_q;
            if (data_addr_ok) begin
              state_d = DB_WAIT;
            end
          end
        end

        DB_WAIT: begin
          if (data_data_ok) begin
            if (discard_q || flush) begin
              // Cancelled access drains here; a follow-on access waits one cycle.
              discard_d = 1'b0;
              stall_req = discard_q && !flush && mem_ce;
              state_d   = DB_IDLE;
            end else begin
              mem_rdata = data_rdata;
              rbuf_d    = data_rdata;
              state_d   = ext_stall ? DB_DONE : DB_IDLE;
            end
          end else if (flush) begin
            discard_d = 1'b1;
          end else if (discard_q) begin
            stall_req = mem_ce;
          end else begin
            stall_req = 1'b1;
          end
        end

        DB_DONE: begin
          if (!ext_stall) begin
            state_d = DB_IDLE;
          end
        end

        default: begin
          state_d = DB_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DB_IDLE;
      discard_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wr_q    <= 1'b0;
      req_size_q  <= SIZE_B;
      req_wdata_q <= '0;
      rbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      req_addr_q  <= req_addr_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_wdata_q <= req_wdata_d;
      rbuf_q      <= rbuf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_sram_bridge.sv
// ============================================================================
// Module  : tb_dmem_sram_bridge
// Brief   : Directed scoreboard bench for dmem_sram_bridge (DMEM_ALIGN_CHK_EN aware).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce, mem_we, flush, ext_stall;
  logic [3:0]  memsel;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_req, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [127:0] outs;
`ifdef DMEM_ALIGN_CHK_EN
  logic        adel, ades;
  assign outs = {adel, ades, mem_rdata, stall_req, data_req, data_wr, data_size, data_addr, data_wdata};
`else
  assign outs = {mem_rdata, stall_req, data_req, data_wr, data_size, data_addr, data_wdata};
`endif

  always #5 clk = ~clk;

  dmem_sram_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ce       (mem_ce),
    .mem_we       (mem_we),
    .memsel       (memsel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .flush        (flush),
    .ext_stall    (ext_stall),
    .mem_rdata    (mem_rdata),
    .stall_req    (stall_req),
`ifdef DMEM_ALIGN_CHK_EN
    .adel         (adel),
    .ades         (ades),
`endif
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        chk_stall;
    logic        stall;
    logic [31:0] rdata;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: bus handshakes pop the request queue, data_ok pops the response queue.
  always @(negedge clk) begin
    req_t er;
    rsp_t es;
    if (!rst) begin
      if (data_req && data_addr_ok) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%h required=none", data_addr);
        end else begin
          er = req_q.pop_front();
          chk("req_fields", {data_addr, data_wr, data_size, data_wdata}, er);
        end
      end
      if (data_data_ok) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=%h required=none", mem_rdata);
        end else begin
          es = rsp_q.pop_front();
          chk("rsp_rdata", mem_rdata, es.rdata);
          if (es.chk_stall) chk("rsp_stall", stall_req, es.stall);
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    mem_ce = 1'b0; mem_we = 1'b0; memsel = 4'b0000; mem_addr = 32'h0; mem_wdata = 32'h0;
    flush = 1'b0; ext_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
  endtask

  task automatic acc(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                     input logic [31:0] wdata);
    mem_ce = 1'b1; mem_we = we; memsel = sel; mem_addr = addr; mem_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_in();
    smp();
    chk("reset_outputs", outs, 128'h0);
    adv(); adv();
    rst = 1'b0;

    // Zero-wait word load
    acc(1'b0, 4'b1111, 32'h100, 32'h11111111);
    data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h100, 1'b0, 2'b10, 32'h11111111}));
    smp(); chk("t1_stall_c0", stall_req, 1'b1);
    adv();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'hDEADBEEF}));
    smp(); chk("t1_req_c1", data_req, 1'b0);
    adv(); idle_in();
    smp(); chk("t1_stall_c2", stall_req, 1'b0);

    // Byte store with addr_ok three cycles late; inputs wander after cycle 0
    adv();
    acc(1'b1, 4'b0001, 32'h103, 32'h5A5A5A5A);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        data_addr_ok = 1'b1;
        req_q.push_back(req_t'({32'h103, 1'b1, 2'b00, 32'h5A5A5A5A}));
      end
      smp();
      chk("t2_req_held", {data_req, stall_req, data_addr, data_wr, data_size, data_wdata},
          {1'b1, 1'b1, 32'h103, 1'b1, 2'b00, 32'h5A5A5A5A});
      adv();
      mem_addr = 32'hFFF; mem_wdata = 32'h0;
    end
    data_addr_ok = 1'b0;
    smp(); chk("t2_wait", {data_req, stall_req}, 2'b01);
    adv();
    data_data_ok = 1'b1; data_rdata = 32'h12345678;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'h12345678}));
    smp();
    adv(); idle_in();

    // Half load completing under ext_stall, then held in DONE
    acc(1'b0, 4'b1100, 32'h200, 32'h0);
    data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h200, 1'b0, 2'b01, 32'h0}));
    smp();
    adv();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D; ext_stall = 1'b1;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'hCAFEF00D}));
    smp();
    adv();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ext_stall = 1'b0;
      smp();
      chk("t3_done_hold", {data_req, stall_req, mem_rdata}, {2'b00, 32'hCAFEF00D});
      adv();
    end

    // Flush while in REQ, then a normal load must issue straight away
    idle_in();
    acc(1'b0, 4'b0010, 32'h302, 32'h0);
    smp(); chk("t4_req", {data_req, stall_req}, 2'b11);
    adv();
    flush = 1'b1;
    smp(); chk("t4_flush_req", {data_req, stall_req}, 2'b00);
    adv();
    flush = 1'b0;
    acc(1'b0, 4'b1111, 32'h304, 32'h0);
    data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h304, 1'b0, 2'b10, 32'h0}));
    smp();
    adv();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'h0BADF00D}));
    smp();
    adv(); idle_in();

    // Flush while in WAIT: late data_ok absorbed, next access held back
    acc(1'b0, 4'b1111, 32'h400, 32'h0);
    data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h400, 1'b0, 2'b10, 32'h0}));
    smp();
    adv();
    data_addr_ok = 1'b0; flush = 1'b1;
    smp(); chk("t4_wait_flush", {data_req, stall_req}, 2'b00);
    adv();
    flush = 1'b0;
    acc(1'b0, 4'b1111, 32'h500, 32'h0);
    smp(); chk("t4_no_issue", data_req, 1'b0);
    adv();
    data_data_ok = 1'b1; data_rdata = 32'hFFFF0000;
    rsp_q.push_back(rsp_t'({1'b0, 1'b0, 32'h0BADF00D}));
    smp(); chk("t4_no_issue_ok", data_req, 1'b0);
    adv();
    data_data_ok = 1'b0; data_rdata = 32'h0; data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h500, 1'b0, 2'b10, 32'h0}));
    smp();
    adv();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h13572468;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'h13572468}));
    smp();
    adv(); idle_in();
    smp(); chk("t4_rbuf", mem_rdata, 32'h13572468);

    // Asynchronous reset in the middle of WAIT
    adv();
    acc(1'b0, 4'b1111, 32'h600, 32'hA5A5A5A5);
    data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h600, 1'b0, 2'b10, 32'hA5A5A5A5}));
    smp();
    adv();
    data_addr_ok = 1'b0;
    #2 rst = 1'b1;
    #1 chk("t5_async_rst", outs, 128'h0);
    adv();
    rst = 1'b0;
    idle_in();
    smp(); chk("t5_after_rst", {stall_req, data_req, mem_rdata}, 34'h0);

    // Stray data_ok in IDLE is dropped; then a 1+1 delayed byte load
    adv();
    data_data_ok = 1'b1; data_rdata = 32'h99999999;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'h0}));
    smp();
    adv();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    acc(1'b0, 4'b0100, 32'h701, 32'h0);
    smp(); chk("t6_c0", {data_req, stall_req}, 2'b11);
    adv();
    data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h701, 1'b0, 2'b00, 32'h0}));
    smp(); chk("t6_c1", stall_req, 1'b1);
    adv();
    smp(); chk("t6_wait", {data_req, stall_req}, 2'b01);
    adv();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2468ACE0;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'h2468ACE0}));
    smp();
    adv(); idle_in();

`ifdef DMEM_ALIGN_CHK_EN
    acc(1'b0, 4'b1111, 32'h102, 32'h0);
    smp(); chk("t7_adel", {adel, ades, data_req, stall_req}, 4'b1000);
    adv();
    acc(1'b1, 4'b0011, 32'h101, 32'h0);
    smp(); chk("t7_ades", {adel, ades, data_req, stall_req}, 4'b0100);
`else
    acc(1'b0, 4'b0110, 32'h800, 32'h0);
    data_addr_ok = 1'b1;
    req_q.push_back(req_t'({32'h800, 1'b0, 2'b10, 32'h0}));
    smp();
    adv();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0F0F0F0F;
    rsp_q.push_back(rsp_t'({1'b1, 1'b0, 32'h0F0F0F0F}));
    smp();
`endif
    adv(); idle_in();
    smp();
    adv();
    chk("queues_drained", {req_q.size(), rsp_q.size()}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Memory-stage bridge between the byte-lane access decoder and the SRAM-like data bus. It consumes the decoder's `mem_ce`, `mem_we`, `memsel` and aligned write data. It issues a single-outstanding request/acknowledge transaction and returns read data to the decoder's `readdata` input. It stalls the pipeline until the transaction completes, and holds the result while later pipeline stalls keep the instruction in M.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; must be 32.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `mem_ce`, in, 1: M-stage access valid.
- `mem_we`, in, 1: 1 = store, 0 = load.
- `memsel`, in, 4: byte lanes. `memsel[3]` is `addr[1:0]==00`.
- `mem_addr`, in, ADDR_W: effective address (`aluoutM`).
- `mem_wdata`, in, 32: lane-replicated store data.
- `flush`, in, 1: M-stage instruction is cancelled (exception/eret).
- `ext_stall`, in, 1: M will not advance this cycle for reasons other than this block.
- `mem_rdata`, out, 32: raw read word to the decoder; reset 0.
- `stall_req`, out, 1: this block holds the pipeline; reset 0.
- `data_req`, out, 1: bus request; reset 0.
- `data_wr`, out, 1: bus write; reset 0.
- `data_size`, out, 2: 00 byte, 01 half, 10 word; reset 0.
- `data_addr`, out, 32: reset 0.
- `data_wdata`, out, 32: reset 0.
- `data_addr_ok`, in, 1: request accepted.
- `data_data_ok`, in, 1: read data valid / write complete.
- `data_rdata`, in, 32: read data.

## Operation
- The state machine has four states: IDLE, REQ, WAIT, DONE.
- IDLE, with `mem_ce & ~flush`:
  - `data_req=1` and `stall_req=1`, combinationally.
  - `data_addr`, `data_wr` and `data_size` are driven from the inputs.
  - If `data_addr_ok`, go to WAIT. Otherwise go to REQ, with the request fields latched.
- REQ:
  - Hold `data_req=1` with the latched fields.
  - On `data_addr_ok`, go to WAIT.
  - On `flush`, drop `data_req` the same cycle and go to IDLE. Nothing was accepted.
- WAIT:
  - `data_req=0`.
  - On `data_data_ok`, `mem_rdata` is driven from `data_rdata` (pass-through) and also captured in `rbuf`.
  - `stall_req` falls that cycle.
  - Next state is DONE if `ext_stall`, otherwise IDLE.
- DONE:
  - `stall_req=0`, `mem_rdata=rbuf`, and no new request is issued.
  - Go to IDLE on the first cycle with `~ext_stall`.
- Flush in WAIT: the transaction must still complete. Set `discard`, keep `stall_req=0`, and absorb `data_data_ok` without updating `rbuf`. A new access may not be issued until `data_data_ok` is absorbed.
- Size decode from `memsel`:
  - 1111 gives word.
  - 1100 or 0011 gives half.
  - A one-hot value gives byte.
  - Any other value gives word, and with checking enabled it raises an exception.
- `data_addr` equals `mem_addr` unmodified. The bus uses the low bits together with `data_size`.
- Only one transaction is outstanding at any time.

## Timing
- Load with zero-wait bus (`addr_ok` in cycle 0, `data_ok` in cycle 1): `stall_req` is high for exactly 1 cycle, and data is valid in cycle 1.
- Each extra cycle of `addr_ok` or `data_ok` delay adds one stall cycle.
- Request fields are stable from request assertion through the `addr_ok` cycle.
- `data_addr_ok` and `data_data_ok` are ignored in states where they are not expected. A `data_data_ok` received in IDLE without a pending access is dropped.
- Reset mid-transaction: all outputs return to reset values immediately and the state goes to IDLE. The bus is assumed reset together with this block.

## Configuration
- `DMEM_ALIGN_CHK_EN` defined:
  - Adds outputs `adel` and `ades` (1 bit each, reset 0).
  - They are asserted combinationally in IDLE when `memsel` is illegal for `mem_addr[1:0]`: half access with odd address, word access with address not `00`, or undecodable `memsel`.
  - `adel` is for loads and `ades` is for stores.
  - No request is issued and `stall_req` stays 0.
- Macro undefined: no such ports and no checking. Every `mem_ce` access is issued.

## Structure
- Shared package holds:
  - State encodings `DB_IDLE`, `DB_REQ`, `DB_WAIT`, `DB_DONE`.
  - Size codes `SIZE_B`, `SIZE_H`, `SIZE_W`.
- One sub-module, `dmem_size_dec`, combinational: `memsel`/`addr[1:0]` → size and legality.

## Test plan
- Zero-wait load, `addr=0x100`, `memsel=1111`, `rdata=0xDEADBEEF` → `data_req` for 1 cycle, `data_size=10`, `mem_rdata=0xDEADBEEF`, `stall_req` high 1 cycle.
- Byte store, `addr=0x103`, `memsel=0001`, `addr_ok` delayed 3 cycles → `data_req` held 4 cycles with stable fields, `data_wr=1`, `data_size=00`.
- Load completes with `ext_stall` high 2 more cycles → DONE holds `mem_rdata=rbuf` with no new `data_req`; then IDLE.
- Flush in REQ → `data_req` low the same cycle; flush in WAIT → late `data_data_ok` absorbed, `rbuf` unchanged, next access waits.
- `rst` pulsed during WAIT → all outputs 0 asynchronously, state IDLE.
- With `DMEM_ALIGN_CHK_EN`: `memsel=1111` at `addr=0x102` load → `adel=1`, `data_req=0`; `memsel=0011` at `0x101` store → `ades=1`.
